// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// | Module : dmem_pkg                                                       |
// | Brief  : Shared constants and helpers for the RV32I data memory.        |
// |          Optional feature macro used by this block: DMEM_ADDR_ERR_EN.   |
// | Rev    : 1.0  initial release                                           |
// ---------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

  // Access size encodings; 2'd3 is treated as a word access.
  localparam logic [1:0] DT_BYTE = 2'd0;
  localparam logic [1:0] DT_HALF = 2'd1;
  localparam logic [1:0] DT_WORD = 2'd2;

  // Default window: 4 KiB starting at 0x0010_0000.
  localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'h0010_0000;
  localparam int          DEFAULT_DEPTH_WORDS = 1024;

  // True when the low address bits do not match the natural alignment of the access.
  function automatic logic is_misaligned(input logic [1:0] dt, input logic [1:0] lo);
    logic r;
    case (dt)
      DT_BYTE: r = 1'b0;
      DT_HALF: r = lo[0];
      default: r = (lo != 2'b00);
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane.sv
// ---------------------------------------------------------------------------
// | Module : dmem_lane                                                      |
// | Brief  : Combinational byte-lane steering for the data memory.          |
// |          Store side: byte enables and lane-replicated write word.       |
// |          Load side : right-justified, zero-extended load value.         |
// | Rev    : 1.0  initial release                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  data_type_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wr_data_i,
  input  logic [31:0] rd_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wr_word_o,
  output logic [31:0] ld_data_o
);

  // Store side: replicate the datum onto every lane and enable only the addressed lanes.
  always_comb begin
    be_o      = 4'b0000;
    wr_word_o = 32'h0;
    case (data_type_i)
      DT_BYTE: begin
        be_o      = 4'b0001 << addr_lo_i;
        wr_word_o = {4{wr_data_i[7:0]}};
      end
      DT_HALF: begin
        be_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wr_word_o = {2{wr_data_i[15:0]}};
      end
      default: begin
        be_o      = 4'b1111;
        wr_word_o = wr_data_i;
      end
    endcase
  end

  // Load side: pick the addressed lane(s), shift down to bit 0 and zero-extend.
  always_comb begin
    ld_data_o = 32'h0;
    case (data_type_i)
      DT_BYTE: begin
        case (addr_lo_i)
          2'd0:    ld_data_o = {24'h0, rd_word_i[7:0]};
          2'd1:    ld_data_o = {24'h0, rd_word_i[15:8]};
          2'd2:    ld_data_o = {24'h0, rd_word_i[23:16]};
          default: ld_data_o = {24'h0, rd_word_i[31:24]};
        endcase
      end
      DT_HALF: ld_data_o = addr_lo_i[1] ? {16'h0, rd_word_i[31:16]} : {16'h0, rd_word_i[15:0]};
      default: ld_data_o = rd_word_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem.sv
// ---------------------------------------------------------------------------
// | Module : dmem                                                           |
// | Brief  : RV32I data memory, word-organised RAM in a fixed base window.  |
// |          Byte-lane stores, combinational zero-extended loads.           |
// |          Define DMEM_ADDR_ERR_EN to add the addr_err output.            |
// | Rev    : 1.0  initial release                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module dmem
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  data_type,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] out_data
`ifdef DMEM_ADDR_ERR_EN
  ,
  output logic        addr_err
`endif
);

  localparam int          c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] c_SPAN  = 32'(4 * DEPTH_WORDS);

  logic [31:0]        mem_q [0:DEPTH_WORDS-1];

  logic [31:0]        w_offset;
  logic               w_in_range;
  logic [c_IDX_W-1:0] w_idx;
  logic [3:0]         w_be;
  logic [31:0]        w_wr_word;
  logic [31:0]        w_rd_word;
  logic [31:0]        w_ld_data;

  // Range decode: the lower-bound test guards against the subtraction wrapping.
  always_comb begin
    w_offset   = addr - BASE_ADDR;
    w_in_range = (addr >= BASE_ADDR) && (w_offset < c_SPAN);
    w_idx      = w_offset[c_IDX_W+1:2];
    w_rd_word  = w_in_range ? mem_q[w_idx] : 32'h0;
  end

  dmem_lane u_lane (
    .data_type_i (data_type),
    .addr_lo_i   (addr[1:0]),
    .wr_data_i   (wr_data),
    .rd_word_i   (w_rd_word),
    .be_o        (w_be),
    .wr_word_o   (w_wr_word),
    .ld_data_o   (w_ld_data)
  );

  // Reset clears every word and blocks stores; otherwise update only the enabled lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (memwrite && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          mem_q[w_idx][8*b +: 8] <= w_wr_word[8*b +: 8];
        end
      end
    end
  end

  // Load result is forced to zero unless a read targets the window.
  always_comb begin
    out_data = (memread && w_in_range) ? w_ld_data : 32'h0;
  end

`ifdef DMEM_ADDR_ERR_EN
  // Flags out-of-window or misaligned accesses; the access itself still proceeds aligned.
  always_comb begin
    addr_err = (memread | memwrite) & (~w_in_range | is_misaligned(data_type, addr[1:0]));
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem.sv
// ---------------------------------------------------------------------------
// | Module : tb_dmem                                                        |
// | Brief  : Self-checking bench for dmem with an expected-value queue.     |
// |          Honours DMEM_ADDR_ERR_EN when defined.                         |
// | Rev    : 1.0  initial release                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dmem;

  logic        clk = 1'b0;
  logic        rst;
  logic        memread;
  logic        memwrite;
  logic [1:0]  data_type;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] out_data;
`ifdef DMEM_ADDR_ERR_EN
  logic        addr_err;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [31:0] sb_q [$];

  always #5 clk = ~clk;

  dmem u_dut (
    .clk       (clk),
    .rst       (rst),
    .memread   (memread),
    .memwrite  (memwrite),
    .data_type (data_type),
    .addr      (addr),
    .wr_data   (wr_data),
    .out_data  (out_data)
`ifdef DMEM_ADDR_ERR_EN
    ,
    .addr_err  (addr_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One store: inputs set mid-cycle, committed on the next rising edge.
  task automatic store(input logic [31:0] a, input logic [1:0] dt, input logic [31:0] d);
    @(negedge clk);
    addr = a; data_type = dt; wr_data = d; memwrite = 1'b1; memread = 1'b0;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
  endtask

  // One load: expected value queued at drive time, popped when the output is sampled.
  task automatic load(input string tag, input logic [31:0] a, input logic [1:0] dt,
                      input logic en, input logic [31:0] exp);
    @(negedge clk);
    addr = a; data_type = dt; memread = en; memwrite = 1'b0;
    sb_q.push_back(exp);
    #1;
    check(tag, out_data, sb_q.pop_front());
    memread = 1'b0;
  endtask

  initial begin
    rst = 1'b1; memread = 1'b0; memwrite = 1'b0;
    data_type = 2'd2; addr = 32'h0; wr_data = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    load("reset_w0", 32'h0010_0000, 2'd2, 1'b1, 32'h0);

    // Half store, word readback
    store(32'h0010_0004, 2'd1, 32'h1234_5678);
    load("half_st", 32'h0010_0004, 2'd2, 1'b1, 32'h0000_5678);

    // Byte lanes and half lanes of a word
    store(32'h0010_0008, 2'd2, 32'hAABB_CCDD);
    load("byte0", 32'h0010_0008, 2'd0, 1'b1, 32'h0000_00DD);
    load("byte1", 32'h0010_0009, 2'd0, 1'b1, 32'h0000_00CC);
    load("byte2", 32'h0010_000A, 2'd0, 1'b1, 32'h0000_00BB);
    load("byte3", 32'h0010_000B, 2'd0, 1'b1, 32'h0000_00AA);
    load("half_hi", 32'h0010_000A, 2'd1, 1'b1, 32'h0000_AABB);
    load("half_lo", 32'h0010_0008, 2'd1, 1'b1, 32'h0000_CCDD);
    load("word_dt3", 32'h0010_0008, 2'd3, 1'b1, 32'hAABB_CCDD);

    // Out-of-range store dropped, out-of-range loads read zero
    store(32'h0000_000C, 2'd2, 32'h1234_5678);
    load("oor_rd_lo", 32'h0000_000C, 2'd2, 1'b1, 32'h0);
    load("oor_rd_hi", 32'h0010_1000, 2'd2, 1'b1, 32'h0);
    load("oor_noalias", 32'h0010_000C, 2'd2, 1'b1, 32'h0);
    load("below_base", 32'h000F_FFFC, 2'd2, 1'b1, 32'h0);

    // Partial stores keep unwritten lanes
    store(32'h0010_000C, 2'd2, 32'hFFFF_FFFF);
    store(32'h0010_000E, 2'd1, 32'h0000_1234);
    load("partial_half", 32'h0010_000C, 2'd2, 1'b1, 32'h1234_FFFF);
    store(32'h0010_000D, 2'd0, 32'hFFFF_FF5A);
    load("partial_byte", 32'h0010_000C, 2'd2, 1'b1, 32'h1234_5AFF);

    // Half store with addr[0]=1 behaves as the aligned half
    store(32'h0010_0011, 2'd1, 32'h0000_BEEF);
    load("half_odd", 32'h0010_0010, 2'd2, 1'b1, 32'h0000_BEEF);

    // Word store with misaligned low bits writes the whole aligned word
    store(32'h0010_0017, 2'd2, 32'h0BAD_F00D);
    load("word_mis", 32'h0010_0014, 2'd2, 1'b1, 32'h0BAD_F00D);

    // Last word in the window
    store(32'h0010_0FFC, 2'd2, 32'hCAFE_F00D);
    load("last_word", 32'h0010_0FFC, 2'd2, 1'b1, 32'hCAFE_F00D);

    // memread low gives zero
    load("rd_off", 32'h0010_0004, 2'd2, 1'b0, 32'h0);

`ifdef DMEM_ADDR_ERR_EN
    @(negedge clk);
    addr = 32'h0010_0005; data_type = 2'd1; memread = 1'b1;
    #1; check("err_half_odd", {31'h0, addr_err}, 32'h1);
    addr = 32'h0010_0004; data_type = 2'd2;
    #1; check("err_word_ok", {31'h0, addr_err}, 32'h0);
    addr = 32'h0010_0006; data_type = 2'd2;
    #1; check("err_word_mis", {31'h0, addr_err}, 32'h1);
    addr = 32'h0000_0000; data_type = 2'd0;
    #1; check("err_oor", {31'h0, addr_err}, 32'h1);
    memread = 1'b0;
    #1; check("err_idle", {31'h0, addr_err}, 32'h0);
`endif

    // Same-cycle read and write: old contents before the edge, new after
    @(negedge clk);
    addr = 32'h0010_0004; data_type = 2'd2; wr_data = 32'h1111_2222;
    memread = 1'b1; memwrite = 1'b1;
    sb_q.push_back(32'h0000_5678);
    #1;
    check("rw_old", out_data, sb_q.pop_front());
    sb_q.push_back(32'h1111_2222);
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    check("rw_new", out_data, sb_q.pop_front());
    memread = 1'b0;

    // Reset clears memory and blocks a concurrent store
    @(negedge clk);
    rst = 1'b1; memwrite = 1'b1; addr = 32'h0010_0004; data_type = 2'd2; wr_data = 32'h0000_0099;
    @(posedge clk);
    #1;
    rst = 1'b0; memwrite = 1'b0;
    load("rst_blk", 32'h0010_0004, 2'd2, 1'b1, 32'h0);
    load("rst_clr", 32'h0010_0008, 2'd2, 1'b1, 32'h0);
    load("rst_last", 32'h0010_0FFC, 2'd2, 1'b1, 32'h0);

    if (sb_q.size() != 0) begin
      check("sb_drain", 32'(sb_q.size()), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
